// File: rtl/mcp3_arb_pkg.sv
// Shared constants and types for the 128-way request arbiter requester side.
package mcp3_arb_pkg;

    localparam int MCP3_ARB_NUM_REQ = 128;
    localparam int MCP3_ARB_IDX_W   = 7;
    localparam int MCP3_ARB_CNT_W   = 8;

    // Winner index layout: {group[6:4], slot[3:0]}
    localparam int GRP_MSB  = 6;
    localparam int GRP_LSB  = 4;
    localparam int SLOT_MSB = 3;

    typedef struct packed {
        logic [GRP_MSB-GRP_LSB:0] grp;
        logic [SLOT_MSB:0]        slot;
    } arb_idx_t;

    typedef enum logic {
        DISP_IDLE = 1'b0,
        DISP_FULL = 1'b1
    } disp_state_t;

    // True when more than one bit of the vector is set.
    function automatic logic is_multi_hot(input logic [MCP3_ARB_NUM_REQ-1:0] vec);
        return (vec & (vec - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/mcp3_decoder7x128.sv
// Combinational 7-to-128 one-hot decoder with enable.
module mcp3_decoder7x128
    import mcp3_arb_pkg::*;
(
    input  logic                        en,
    input  logic [MCP3_ARB_IDX_W-1:0]   idx,
    output logic [MCP3_ARB_NUM_REQ-1:0] onehot
);

    always_comb begin
        // NOTE: default first so every path assigns onehot; no latch is inferred.
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mcp3_arb128_req_ctl.sv
// Requester side of the 128-way arbiter: pending request bits, pending counter,
// one-entry dispatch register and sticky protocol-error flags.
module mcp3_arb128_req_ctl
    import mcp3_arb_pkg::*;
#(
    parameter int NUM_REQ = MCP3_ARB_NUM_REQ,
    parameter int CNT_W   = MCP3_ARB_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               set_valid,
    input  logic [6:0]         set_idx,
    output logic [NUM_REQ-1:0] req_bus,
    input  logic               arb_valid,
    input  logic [6:0]         arb_winner,
    input  logic [NUM_REQ-1:0] arb_req_clear,
    output logic               arb_req_taken,
    output logic               dispatch_valid,
    output logic [6:0]         dispatch_idx,
    input  logic               dispatch_ready,
    output logic [CNT_W-1:0]   pending_cnt,
    output logic               empty,
    output logic               set_collision,
    output logic               clear_err
);

    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] pend_nxt;
    logic [NUM_REQ-1:0] set_onehot;
    logic [NUM_REQ-1:0] clear_hit;
    logic               set_hit;
    logic               cnt_inc;
    logic               cnt_dec;
    logic               collision;
    logic               clear_bad;
    logic [CNT_W-1:0]   cnt_nxt;

    disp_state_t        disp_state;
    disp_state_t        disp_state_nxt;
    arb_idx_t           disp_idx_q;

    mcp3_decoder7x128 u_set_dec (
        .en     (set_valid),
        .idx    (set_idx),
        .onehot (set_onehot)
    );

    // A set only counts as new if the slot is not still pending after this cycle's clear.
    assign set_hit   = pend[set_idx] & ~arb_req_clear[set_idx];
    assign collision = set_valid & set_hit;
    assign cnt_inc   = set_valid & ~set_hit;
    assign clear_hit = pend & arb_req_clear;
    assign cnt_dec   = |clear_hit;
    assign clear_bad = (|(arb_req_clear & ~pend)) | is_multi_hot(arb_req_clear);
    assign pend_nxt  = (pend & ~arb_req_clear) | set_onehot;
    assign cnt_nxt   = pending_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend          <= '0;
            pending_cnt   <= '0;
            set_collision <= 1'b0;
            clear_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            pend        <= pend_nxt;
            pending_cnt <= cnt_nxt;
            if (collision) begin
                set_collision <= 1'b1;
            end
            if (clear_bad) begin
                clear_err <= 1'b1;
            end
        end
    end

    // Dispatch register: accept a winner whenever empty or being drained this cycle.
    assign arb_req_taken = arb_valid & ((disp_state == DISP_IDLE) | dispatch_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_state <= DISP_IDLE;
        end else begin
            disp_state <= disp_state_nxt;
        end
    end

    always_comb begin
        disp_state_nxt = disp_state;
        case (disp_state)
            DISP_IDLE: begin
                if (arb_req_taken) begin
                    disp_state_nxt = DISP_FULL;
                end
            end
            DISP_FULL: begin
                if (!arb_req_taken && dispatch_ready) begin
                    disp_state_nxt = DISP_IDLE;
                end
            end
            default: disp_state_nxt = DISP_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_idx_q <= '0;
        end else if (arb_req_taken) begin
            disp_idx_q <= arb_idx_t'(arb_winner);
        end
    end

    assign req_bus        = pend;
    assign dispatch_valid = (disp_state == DISP_FULL);
    assign dispatch_idx   = disp_idx_q;
    assign empty          = (pending_cnt == '0) & ~dispatch_valid;

endmodule
